// File: rtl/quotient_bcd_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quotient_bcd_converter_pkg
//  Description : Shared definitions for the quotient formatting path: BCD
//                digit width, the shift-add-3 correction threshold and the
//                converter state encoding. Reused by the divider and the
//                other formatter stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package quotient_bcd_converter_pkg;

    // Width of one packed BCD digit.
    localparam int unsigned C_BCD_DIGIT_W = 4;

    // A digit at or above this value is corrected by +3 before each shift,
    // so that doubling it carries correctly into the next decade.
    localparam logic [C_BCD_DIGIT_W-1:0] C_ADD3_THRESHOLD = 4'd5;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage : quotient_bcd_converter_pkg
`default_nettype wire

// File: rtl/quotient_bcd_converter_bcd_add3_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3_digit
//  Description : Combinational single-digit corrector for the double-dabble
//                algorithm. Adds 3 to the digit when it is 5 or more,
//                otherwise passes it through unchanged.
//  Ports       : i_digit  - BCD digit before correction
//                o_digit  - corrected digit, ready to be shifted left
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_digit
    import quotient_bcd_converter_pkg::*;
(
    input  logic [C_BCD_DIGIT_W-1:0] i_digit,
    output logic [C_BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        if (i_digit >= C_ADD3_THRESHOLD) begin
            o_digit = i_digit + C_BCD_DIGIT_W'(3);
        end else begin
            o_digit = i_digit;
        end
    end

endmodule : bcd_add3_digit
`default_nettype wire

// File: rtl/quotient_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : quotient_bcd_converter
//  Description : Sequential binary-to-BCD converter (shift-add-3, one bit per
//                clock) sitting behind the 16-bit unsigned divider. Captures
//                the quotient on in_valid and emits DIGITS packed BCD digits
//                with a one-cycle bcd_valid pulse. A one-entry hold buffer
//                queues a result that arrives while a conversion is running;
//                a further arrival is dropped and flagged in sticky overrun.
//  Ports       : clock          - system clock, rising edge
//                reset          - asynchronous active-high reset
//                in_valid       - one-cycle strobe, in_data is valid
//                in_data        - unsigned value to convert
//                clear_overrun  - synchronous clear of overrun
//                in_ready       - hold buffer empty (informational)
//                busy           - conversion in progress (SHIFT or DONE)
//                bcd_valid      - one-cycle strobe, bcd_out is valid
//                bcd_out        - packed BCD, units digit in bits [3:0]
//                overrun        - sticky, a value was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module quotient_bcd_converter
    import quotient_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               clear_overrun,
    output logic                               in_ready,
    output logic                               busy,
    output logic                               bcd_valid,
    output logic [C_BCD_DIGIT_W*DIGITS-1:0]    bcd_out,
    output logic                               overrun
);

    localparam int C_BCD_W = C_BCD_DIGIT_W * DIGITS;
    localparam int C_SR_W  = C_BCD_W + WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    conv_state_t          r_state;
    conv_state_t          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [C_SR_W-1:0]    r_shift;       // {bcd field, binary field}
    logic [WIDTH-1:0]     r_hold_data;
    logic                 r_hold_full;
    logic                 r_bcd_valid;
    logic [C_BCD_W-1:0]   r_bcd_out;
    logic                 r_overrun;

    // ------------------------------------------------------------------
    // Datapath: correct every digit in parallel, then shift left by one
    // ------------------------------------------------------------------
    logic [C_BCD_W-1:0]   w_bcd_corr;
    logic [C_SR_W-1:0]    w_shift_src;
    logic [C_SR_W-1:0]    w_shifted;
    logic                 w_last_iter;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_shift[WIDTH + gi*C_BCD_DIGIT_W +: C_BCD_DIGIT_W]),
            .o_digit (w_bcd_corr[gi*C_BCD_DIGIT_W +: C_BCD_DIGIT_W])
        );
    end

    assign w_shift_src = {w_bcd_corr, r_shift[WIDTH-1:0]};
    assign w_shifted   = w_shift_src << 1;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Control: next state, converter load source, hold-buffer actions
    // ------------------------------------------------------------------
    logic                 w_start;       // load a new value into r_shift
    logic [WIDTH-1:0]     w_start_data;
    logic                 w_pop;         // hold buffer feeds the converter
    logic                 w_direct;      // in_data goes straight to r_shift
    logic                 w_push;        // in_data captured into hold buffer
    logic                 w_drop;        // in_data discarded

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_data = in_data;
        w_pop        = 1'b0;
        w_direct     = 1'b0;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_start      = 1'b1;
                    w_direct     = 1'b1;
                    w_state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (w_last_iter) begin
                    w_state_next = DONE;
                end
            end

            DONE: begin
                if (r_hold_full) begin
                    w_start      = 1'b1;
                    w_start_data = r_hold_data;
                    w_pop        = 1'b1;
                    w_state_next = SHIFT;
                end else if (in_valid) begin
                    // Buffer empty and the converter frees up on this very
                    // edge: start the new value directly. Parking it in the
                    // buffer would leave a full buffer in IDLE and cost a
                    // cycle of latency for nothing.
                    w_start      = 1'b1;
                    w_direct     = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A pop on the same edge frees the slot, so the new value takes it.
    assign w_push = in_valid && !w_direct && (!r_hold_full || w_pop);
    assign w_drop = in_valid && !w_direct && r_hold_full && !w_pop;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_shift <= {{C_BCD_W{1'b0}}, w_start_data};
        end else if (r_state == SHIFT) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= w_shifted;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcd_valid <= 1'b0;
            r_bcd_out   <= '0;
        end else begin
            r_bcd_valid <= (r_state == SHIFT) && w_last_iter;
            if ((r_state == SHIFT) && w_last_iter) begin
                r_bcd_out <= w_shifted[C_SR_W-1 -: C_BCD_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_push) begin
            r_hold_full <= 1'b1;
            r_hold_data <= in_data;
        end else if (w_pop) begin
            r_hold_full <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = !r_hold_full;
    assign busy      = (r_state != IDLE);
    assign bcd_valid = r_bcd_valid;
    assign bcd_out   = r_bcd_out;
    assign overrun   = r_overrun;

endmodule : quotient_bcd_converter
`default_nettype wire

// File: tb/tb_quotient_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quotient_bcd_converter
//  Description : Self-checking bench for quotient_bcd_converter. Directed
//                vector table, hand-written multi-cycle sequences and a
//                randomized run, all compared cycle by cycle against a
//                behavioural model of the conversion timing and buffering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quotient_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = 16;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              clear_overrun;
    logic              in_ready;
    logic              busy;
    logic              bcd_valid;
    logic [19:0]       bcd_out;
    logic              overrun;

    quotient_bcd_converter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .CNT_W  (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .clear_overrun (clear_overrun),
        .in_ready      (in_ready),
        .busy          (busy),
        .bcd_valid     (bcd_valid),
        .bcd_out       (bcd_out),
        .overrun       (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    logic [19:0] got[$];
    int          got_t[$];

    // ------------------------------------------------------------------
    // Behavioural model: a conversion takes LAT edges from its start, the
    // result is visible for one cycle, and one value may wait behind it.
    // ------------------------------------------------------------------
    int          m_rem;
    bit          m_pulse;
    logic [15:0] m_value;
    bit          m_hold_full;
    logic [15:0] m_hold_val;
    logic [19:0] m_out;
    bit          m_ovr;

    function automatic logic [19:0] to_bcd(int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_rem = 0; m_pulse = 0; m_value = '0;
        m_hold_full = 0; m_hold_val = '0; m_out = '0; m_ovr = 0;
    endtask

    task automatic model_step(bit iv, logic [15:0] d, bit clr);
        bit          was_pulse;
        bit          start;
        bit          drop;
        logic [15:0] sv;
        was_pulse = m_pulse;
        m_pulse   = 0;
        start     = 0;
        drop      = 0;
        sv        = d;
        if (was_pulse) begin
            if (m_hold_full) begin
                start = 1; sv = m_hold_val;
                m_hold_full = iv;
                if (iv) m_hold_val = d;
            end else if (iv) begin
                start = 1; sv = d;
            end
        end else if (m_rem == 0) begin
            if (iv) begin start = 1; sv = d; end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_pulse = 1;
                m_out   = to_bcd(int'(m_value));
            end
            if (iv) begin
                if (!m_hold_full) begin m_hold_full = 1; m_hold_val = d; end
                else drop = 1;
            end
        end
        if (start) begin m_value = sv; m_rem = LAT; end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic cycle(bit iv, logic [15:0] d, bit clr);
        in_valid      = iv;
        in_data       = d;
        clear_overrun = clr;
        model_step(iv, d, clr);
        @(posedge clock);
        @(negedge clock);
        ncyc++;
        check("bcd_valid", 32'(bcd_valid), 32'(m_pulse));
        check("bcd_out",   32'(bcd_out),   32'(m_out));
        check("busy",      32'(busy),      32'((m_rem != 0) || m_pulse));
        check("in_ready",  32'(in_ready),  32'(!m_hold_full));
        check("overrun",   32'(overrun),   32'(m_ovr));
        if (bcd_valid) begin
            got.push_back(bcd_out);
            got_t.push_back(ncyc);
        end
    endtask

    task automatic wait_pulses(int n, int bound);
        int k;
        k = 0;
        while (got.size() < n && k < bound) begin
            cycle(0, '0, 0);
            k++;
        end
        if (got.size() < n) check("pulse_timeout", 32'(got.size()), 32'(n));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        check("rst_bcd_out",   32'(bcd_out),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_overrun",   32'(overrun),   32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [19:0] exp_bcd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; in_valid = 0; in_data = '0; clear_overrun = 0;
        model_reset();

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd65535, 20'h65535};
        vecs[2] = '{16'd1234,  20'h01234};
        vecs[3] = '{16'd9,     20'h00009};
        vecs[4] = '{16'd10,    20'h00010};
        vecs[5] = '{16'd99,    20'h00099};
        vecs[6] = '{16'd40960, 20'h40960};
        vecs[7] = '{16'd59999, 20'h59999};

        repeat (2) @(negedge clock);
        apply_reset();

        // Directed vectors: value, latency and single-cycle pulse.
        foreach (vecs[i]) begin
            got.delete(); got_t.delete();
            cycle(1, vecs[i].value, 0);
            t0 = ncyc;
            wait_pulses(1, LAT + 4);
            if (got.size() >= 1) begin
                check("vec_latency", 32'(got_t[0] - t0), 32'(LAT));
                check("vec_value",   32'(got[0]),        32'(vecs[i].exp_bcd));
            end
            cycle(0, '0, 0);
            check("vec_pulse_len", 32'(bcd_valid), 32'd0);
        end

        // Back-to-back: second value held while the first converts.
        got.delete(); got_t.delete();
        cycle(1, 16'd100, 0);
        t0 = ncyc;
        repeat (4) cycle(0, '0, 0);
        cycle(1, 16'd200, 0);
        check("b2b_in_ready", 32'(in_ready), 32'd0);
        wait_pulses(2, 40);
        if (got.size() >= 2) begin
            check("b2b_first_lat", 32'(got_t[0] - t0),       32'(LAT));
            check("b2b_spacing",   32'(got_t[1] - got_t[0]), 32'(LAT + 1));
            check("b2b_first",     32'(got[0]),              32'h00100);
            check("b2b_second",    32'(got[1]),              32'h00200);
        end
        check("b2b_overrun", 32'(overrun), 32'd0);
        repeat (2) cycle(0, '0, 0);

        // Three values in one conversion: third is dropped.
        got.delete(); got_t.delete();
        cycle(1, 16'd1, 0);
        cycle(0, '0, 0);
        cycle(1, 16'd2, 0);
        cycle(0, '0, 0);
        cycle(1, 16'd3, 0);
        check("drop_overrun_set", 32'(overrun), 32'd1);
        wait_pulses(2, 45);
        repeat (3) cycle(0, '0, 0);
        check("drop_pulse_count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            check("drop_first",  32'(got[0]), 32'h00001);
            check("drop_second", 32'(got[1]), 32'h00002);
        end
        check("drop_overrun_sticky", 32'(overrun), 32'd1);
        cycle(0, '0, 1);
        check("drop_overrun_clear", 32'(overrun), 32'd0);

        // New value in the DONE cycle while the buffer holds another.
        got.delete(); got_t.delete();
        cycle(1, 16'd10, 0);
        repeat (2) cycle(0, '0, 0);
        cycle(1, 16'd20, 0);
        repeat (13) cycle(0, '0, 0);
        check("done_push_pulse", 32'(bcd_valid), 32'd1);
        cycle(1, 16'd30, 0);
        check("done_push_held", 32'(in_ready), 32'd0);
        wait_pulses(3, 45);
        repeat (3) cycle(0, '0, 0);
        check("done_push_count", 32'(got.size()), 32'd3);
        if (got.size() >= 3) begin
            check("done_push_0", 32'(got[0]), 32'h00010);
            check("done_push_1", 32'(got[1]), 32'h00020);
            check("done_push_2", 32'(got[2]), 32'h00030);
        end
        check("done_push_overrun", 32'(overrun), 32'd0);

        // Reset at iteration 8 aborts the conversion and the held value.
        got.delete(); got_t.delete();
        cycle(1, 16'd777, 0);
        cycle(1, 16'd555, 0);
        repeat (7) cycle(0, '0, 0);
        apply_reset();
        repeat (LAT + 4) cycle(0, '0, 0);
        check("abort_no_pulse", 32'(got.size()), 32'd0);
        cycle(1, 16'd42, 0);
        wait_pulses(1, LAT + 4);
        if (got.size() >= 1) check("abort_fresh", 32'(got[0]), 32'h00042);
        repeat (2) cycle(0, '0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 7) == 0, 16'($urandom),
                  $urandom_range(0, 15) == 0);
        end
        repeat (LAT * 3) cycle(0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_quotient_bcd_converter
`default_nettype wire
